// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit
// ----------------------------------------------------------------------------
// Iterative multiply/divide unit owning the HI/LO register pair.
//   MULT/MULTU : {hi,lo} = full 2*WIDTH-bit product (signed / unsigned)
//   DIV/DIVU   : lo = quotient (truncated toward zero), hi = remainder
//                (signed remainder follows the dividend's sign)
//   MTHI/MTLO  : single-edge move of 'a' into hi or lo
// One shift-add / restoring-subtract step is taken per cycle, so an accepted
// multiply or divide keeps 'busy' high for exactly WIDTH cycles, writes hi/lo
// on the WIDTH-th edge and pulses 'done' in the following cycle.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous reset, active-high
//   start        in   1      request strobe (ignored while busy)
//   op           in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                            100 MTHI, 101 MTLO, others NOP
//   a            in   WIDTH  multiplicand / dividend / move source
//   b            in   WIDTH  multiplier / divisor
//   busy         out  1      iteration in progress
//   done         out  1      one-cycle pulse after hi/lo were updated
//   div_by_zero  out  1      qualified by done; DIV/DIVU with b==0
//   hi           out  WIDTH  HI register
//   lo           out  WIDTH  LO register
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_FINISH = 2'b10
    } state_t;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    // Two's-complement negate of a WIDTH-bit value when 'neg' is set.
    function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v,
                                                   input logic             neg);
        logic [WIDTH-1:0] res;
        if (neg) begin
            res = {WIDTH{1'b0}} - v;
        end else begin
            res = v;
        end
        return res;
    endfunction

    // Two's-complement negate of a 2*WIDTH-bit value when 'neg' is set.
    function automatic logic [2*WIDTH-1:0] cond_neg_d(input logic [2*WIDTH-1:0] v,
                                                     input logic               neg);
        logic [2*WIDTH-1:0] res;
        if (neg) begin
            res = {(2*WIDTH){1'b0}} - v;
        end else begin
            res = v;
        end
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    // Working register: multiply -> {partial product, remaining multiplier};
    // divide -> {partial remainder, dividend bits / quotient bits}.
    logic [2*WIDTH-1:0] r_p;
    logic [WIDTH-1:0]   r_d;        // multiplicand / divisor magnitude
    logic               r_is_div;
    logic               r_neg_lo;   // negate product / quotient at the end
    logic               r_neg_hi;   // negate remainder at the end (divide only)
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz;

    // ------------------------------------------------------------------------
    // Wires
    // ------------------------------------------------------------------------
    state_t             w_state_nxt;
    logic               w_can_accept;
    logic               w_accept_run;
    logic               w_accept_dbz;
    logic               w_mthi;
    logic               w_mtlo;
    logic               w_signed;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_neg_lo;
    logic               w_neg_hi;
    logic               w_last;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_step;
    logic [WIDTH:0]     w_div_shift;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_sub;
    logic [WIDTH-1:0]   w_div_rem;
    logic [2*WIDTH-1:0] w_div_step;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_hi_res;
    logic [WIDTH-1:0]   w_lo_res;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_dbz_nxt;

    // Request decode: a request is only seen outside RUN; op[2]==0 selects
    // the iterative operations, op[1] selects divide, op[0]==0 means signed.
    always_comb begin
        w_can_accept = start && (r_state != S_RUN);
        w_accept_run = 1'b0;
        w_accept_dbz = 1'b0;
        if (w_can_accept && (op[2] == 1'b0)) begin
            if (op[1] && (b == {WIDTH{1'b0}})) begin
                w_accept_dbz = 1'b1;
            end else begin
                w_accept_run = 1'b1;
            end
        end else begin
            w_accept_run = 1'b0;
            w_accept_dbz = 1'b0;
        end
        w_mthi = w_can_accept && (op == OP_MTHI);
        w_mtlo = w_can_accept && (op == OP_MTLO);
    end

    // Operand magnitudes and result-sign flags captured at acceptance.
    always_comb begin
        w_signed = (op[0] == 1'b0);
        w_sign_a = w_signed && a[WIDTH-1];
        w_sign_b = w_signed && b[WIDTH-1];
        w_a_mag  = cond_neg_w(a, w_sign_a);
        w_b_mag  = cond_neg_w(b, w_sign_b);
        w_neg_lo = w_sign_a ^ w_sign_b;
        if (op[1]) begin
            w_neg_hi = w_sign_a;
        end else begin
            w_neg_hi = w_sign_a ^ w_sign_b;
        end
    end

    // One iteration step for both algorithms, plus final sign correction.
    always_comb begin
        // Shift-add: conditionally add multiplicand into the upper half,
        // then shift the whole register right by one.
        if (r_p[0]) begin
            w_mul_sum = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, r_d};
        end else begin
            w_mul_sum = {1'b0, r_p[2*WIDTH-1:WIDTH]};
        end
        w_mul_step = {w_mul_sum, r_p[WIDTH-1:1]};

        // Restoring divide: bring down the next dividend bit and subtract
        // the divisor if it fits. The difference is below the divisor, so
        // the low WIDTH bits of the modular subtraction are exact.
        w_div_shift = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
        w_div_ge    = (w_div_shift >= {1'b0, r_d});
        w_div_sub   = w_div_shift[WIDTH-1:0] - r_d;
        if (w_div_ge) begin
            w_div_rem = w_div_sub;
        end else begin
            w_div_rem = w_div_shift[WIDTH-1:0];
        end
        w_div_step = {w_div_rem, r_p[WIDTH-2:0], w_div_ge};

        if (r_is_div) begin
            w_step = w_div_step;
        end else begin
            w_step = w_mul_step;
        end

        w_prod_fix = cond_neg_d(w_step, r_neg_lo);
        if (r_is_div) begin
            w_hi_res = cond_neg_w(w_step[2*WIDTH-1:WIDTH], r_neg_hi);
            w_lo_res = cond_neg_w(w_step[WIDTH-1:0], r_neg_lo);
        end else begin
            w_hi_res = w_prod_fix[2*WIDTH-1:WIDTH];
            w_lo_res = w_prod_fix[WIDTH-1:0];
        end
        w_last = (r_cnt == CW'(1));
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; FINISH accepts a new request just like IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_FINISH: begin
                if (w_accept_run) begin
                    w_state_nxt = S_RUN;
                end else if (w_accept_dbz) begin
                    w_state_nxt = S_FINISH;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_FINISH;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM output decode from the next state, so the flags can be registered
    // and still line up with the state they describe.
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        w_dbz_nxt  = 1'b0;
        case (w_state_nxt)
            S_RUN: begin
                w_busy_nxt = 1'b1;
            end
            S_FINISH: begin
                w_done_nxt = 1'b1;
                w_dbz_nxt  = w_accept_dbz;
            end
            default: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b0;
                w_dbz_nxt  = 1'b0;
            end
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            r_dbz  <= w_dbz_nxt;
        end
    end

    // Iteration datapath: load operands on acceptance, step while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= {CW{1'b0}};
            r_p      <= {(2*WIDTH){1'b0}};
            r_d      <= {WIDTH{1'b0}};
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_p   <= w_step;
            r_cnt <= r_cnt - CW'(1);
        end else if (w_accept_run) begin
            r_cnt    <= CW'(WIDTH);
            r_p      <= {{WIDTH{1'b0}}, w_a_mag};
            r_d      <= w_b_mag;
            r_is_div <= op[1];
            r_neg_lo <= w_neg_lo;
            r_neg_hi <= w_neg_hi;
        end else begin
            r_cnt <= r_cnt;
            r_p   <= r_p;
        end
    end

    // HI/LO architectural registers: written only by moves or by the final
    // iteration, so reads during RUN see the previous values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= {WIDTH{1'b0}};
            r_lo <= {WIDTH{1'b0}};
        end else if ((r_state == S_RUN) && w_last) begin
            r_hi <= w_hi_res;
            r_lo <= w_lo_res;
        end else begin
            if (w_mthi) begin
                r_hi <= a;
            end else begin
                r_hi <= r_hi;
            end
            if (w_mtlo) begin
                r_lo <= a;
            end else begin
                r_lo <= r_lo;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): a table of directed
// multiply/divide vectors plus hand-written handshake corner sequences.
module tb_muldiv_unit;

    localparam logic [2:0] MULT  = 3'b000;
    localparam logic [2:0] MULTU = 3'b001;
    localparam logic [2:0] DIV   = 3'b010;
    localparam logic [2:0] DIVU  = 3'b011;
    localparam logic [2:0] MTHI  = 3'b100;
    localparam logic [2:0] MTLO  = 3'b101;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[13];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request at a negedge and wait (bounded) for done. Returns at
    // the negedge where done is high. Inputs are scrambled while busy.
    task automatic run_op(input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                          output int bcnt, output bit got_done, output bit held_ok);
        logic [31:0] h0;
        logic [31:0] l0;
        h0 = hi;
        l0 = lo;
        bcnt = 0;
        got_done = 1'b0;
        held_ok = 1'b1;
        @(negedge clk);
        start = 1'b1; op = t_op; a = t_a; b = t_b;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (busy) begin
                bcnt++;
                if ((hi !== h0) || (lo !== l0)) held_ok = 1'b0;
            end
            a = $urandom;
            b = $urandom;
            op = 3'($urandom_range(0, 7));
            @(negedge clk);
        end
    endtask

    // Single-edge move into hi or lo.
    task automatic move(input logic [2:0] t_op, input logic [31:0] t_a);
        @(negedge clk);
        start = 1'b1; op = t_op; a = t_a; b = 32'd0;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int  bcnt;
        bit  got;
        bit  held;
        bit  quiet;

        n_cmp = 0;
        n_fail = 0;

        vecs[0]  = '{MULTU, 32'd7,          32'd6,          32'h00000000, 32'h0000002A};
        vecs[1]  = '{MULT,  32'hFFFFFFFD,   32'd5,          32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{MULTU, 32'hFFFFFFFF,   32'd2,          32'h00000001, 32'hFFFFFFFE};
        vecs[3]  = '{DIVU,  32'd100,        32'd7,          32'h00000002, 32'h0000000E};
        vecs[4]  = '{DIV,   32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[5]  = '{DIV,   32'h80000000,   32'hFFFFFFFF,   32'h00000000, 32'h80000000};
        vecs[6]  = '{MULT,  32'h80000000,   32'h80000000,   32'h40000000, 32'h00000000};
        vecs[7]  = '{MULT,  32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000, 32'h00000001};
        vecs[8]  = '{DIV,   32'd7,          32'hFFFFFFFE,   32'h00000001, 32'hFFFFFFFD};
        vecs[9]  = '{DIVU,  32'hFFFFFFFF,   32'd1,          32'h00000000, 32'hFFFFFFFF};
        vecs[10] = '{DIVU,  32'd5,          32'd9,          32'h00000005, 32'h00000000};
        vecs[11] = '{MULTU, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 32'h00000001};
        vecs[12] = '{MULT,  32'd12345,      32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFCFC7};

        // Reset state
        rst = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_hi",   {32'd0, hi}, 64'd0);
        check("reset_lo",   {32'd0, lo}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_dbz",  {63'd0, div_by_zero}, 64'd0);

        // Table-driven arithmetic vectors
        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, bcnt, got, held);
            check($sformatf("v%0d_done", i),  {63'd0, got}, 64'd1);
            check($sformatf("v%0d_busy_cycles", i), 64'(bcnt), 64'd32);
            check($sformatf("v%0d_held", i),  {63'd0, held}, 64'd1);
            check($sformatf("v%0d_hi", i),    {32'd0, hi}, {32'd0, vecs[i].exp_hi});
            check($sformatf("v%0d_lo", i),    {32'd0, lo}, {32'd0, vecs[i].exp_lo});
            check($sformatf("v%0d_dbz", i),   {63'd0, div_by_zero}, 64'd0);
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), {63'd0, done}, 64'd0);
        end

        // MTHI then MTLO on consecutive edges
        @(negedge clk);
        start = 1'b1; op = MTHI; a = 32'h12345678;
        @(negedge clk);
        check("mthi_hi",   {32'd0, hi}, 64'h12345678);
        check("mthi_done", {62'd0, done, busy}, 64'd0);
        op = MTLO; a = 32'd9;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_lo",   {32'd0, lo}, 64'd9);
        check("mtlo_hi",   {32'd0, hi}, 64'h12345678);
        check("mtlo_done", {62'd0, done, busy}, 64'd0);

        // Divide by zero leaves hi/lo untouched
        move(MTHI, 32'hAA);
        move(MTLO, 32'hBB);
        @(negedge clk);
        start = 1'b1; op = DIV; a = 32'd5; b = 32'd0;
        @(negedge clk);
        start = 1'b0;
        check("dbz_done", {63'd0, done}, 64'd1);
        check("dbz_flag", {63'd0, div_by_zero}, 64'd1);
        check("dbz_busy", {63'd0, busy}, 64'd0);
        check("dbz_hi",   {32'd0, hi}, 64'hAA);
        check("dbz_lo",   {32'd0, lo}, 64'hBB);
        @(negedge clk);
        check("dbz_clear", {62'd0, done, div_by_zero}, 64'd0);

        // Start while busy is ignored
        @(negedge clk);
        start = 1'b1; op = MULTU; a = 32'd7; b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        bcnt = 0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) bcnt++;
            if (i == 5) begin
                start = 1'b1; op = MULTU; a = 32'd3; b = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("ign_done", {63'd0, got}, 64'd1);
        check("ign_busy_cycles", 64'(bcnt), 64'd32);
        check("ign_lo", {32'd0, lo}, 64'd42);

        // Start during FINISH is accepted
        start = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", {62'd0, busy, done}, 64'd2);
        bcnt = 0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) bcnt++;
            @(negedge clk);
        end
        check("b2b_done", {63'd0, got}, 64'd1);
        check("b2b_busy_cycles", 64'(bcnt), 64'd32);
        check("b2b_lo", {32'd0, lo}, 64'd14);
        check("b2b_hi", {32'd0, hi}, 64'd2);

        // Reset in the middle of RUN
        @(negedge clk);
        start = 1'b1; op = MULTU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("rrun_busy_before", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rrun_hi",   {32'd0, hi}, 64'd0);
        check("rrun_lo",   {32'd0, lo}, 64'd0);
        check("rrun_busy", {63'd0, busy}, 64'd0);
        quiet = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) quiet = 1'b0;
            @(negedge clk);
        end
        check("rrun_no_done", {63'd0, quiet}, 64'd1);
        check("rrun_lo_after", {32'd0, lo}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
